// File: rtl/ball_slot_scheduler_pkg.sv
// ball_pkg: shared slot state encoding and player constants for the ball slot scheduler
package ball_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LAUNCH = 2'd1,
    FLIGHT = 2'd2
  } slot_state_t;
  localparam int PLAYER0 = 0;
  localparam int PLAYER1 = 1;
  localparam int NUM_PLAYERS = 2;
endpackage

// File: rtl/ball_slot_scheduler_if.sv
// ball_slot_scheduler_if: per-slot summon/summoned bundle between the scheduler and the ball instances
// slot_summon : one-frame summon strobe per slot (scheduler -> ball)
// slot_owner  : owning player per slot, latched at grant (scheduler -> top-level mux)
// slot_face   : facing latched at grant (scheduler -> ball)
// slot_active : summoned flag returned by each ball (ball -> scheduler)
interface ball_slot_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic [NUM_SLOTS-1:0] slot_summon;
  logic [NUM_SLOTS-1:0] slot_owner;
  logic [NUM_SLOTS-1:0] slot_face;
  logic [NUM_SLOTS-1:0] slot_active;
  modport master(output slot_summon, slot_owner, slot_face, input slot_active);
  modport slave(input slot_summon, slot_owner, slot_face, output slot_active);
endinterface

// File: rtl/ball_slot_scheduler_fsm.sv
// ball_slot_fsm: one slot's FREE/LAUNCH/FLIGHT tracker with owner and face latched at grant
// frame_clk, Reset_n   : frame clock, asynchronous active-low reset
// grant_en             : slot is granted this frame (only honoured while FREE)
// grant_owner/face     : player and facing to latch on grant
// slot_active          : summoned flag from the ball
// summon               : high for the single LAUNCH frame
// owner, face          : latched values
// is_free, is_owned_by : slot is FREE / slot is held (LAUNCH or FLIGHT) by player p
module ball_slot_fsm
  import ball_pkg::*;
(
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   grant_en,
  input  logic                   grant_owner,
  input  logic                   grant_face,
  input  logic                   slot_active,
  output logic                   summon,
  output logic                   owner,
  output logic                   face,
  output logic                   is_free,
  output logic [NUM_PLAYERS-1:0] is_owned_by
);
  slot_state_t state;
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= FREE;
      owner <= 1'b0;
      face  <= 1'b0;
    end else begin
      state <= (state == FREE) ? (grant_en ? LAUNCH : FREE) :
               (state == LAUNCH) ? FLIGHT : (slot_active ? FLIGHT : FREE);
      if (grant_en && state == FREE) begin
        owner <= grant_owner;
        face  <= grant_face;
      end
    end
  assign summon = state == LAUNCH;
  assign is_free = state == FREE;
  assign is_owned_by = {!is_free && owner, !is_free && !owner};
endmodule

// File: rtl/ball_slot_scheduler.sv
// ball_slot_scheduler: arbitrates two players' fire requests onto a pool of ball slots
// frame_clk, Reset_n      : frame clock, asynchronous active-low reset
// fire_req, face, reload  : per-player request level, facing, ammo refill pulse
// slots                   : summon/owner/face out, slot_active in, one bit per slot
// grant                   : one-frame pulse per player, aligned with the slot's LAUNCH frame
// active_cnt0/1           : slots held by each player
// rr_prio                 : player favoured when both contend for the last free slot
// Optional feature macro AMMO_LIMIT_EN adds a per-player ammo counter refilled by reload.
module ball_slot_scheduler
  import ball_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int COOLDOWN = 10,
  parameter int MAX_PER_PLAYER = 2,
  parameter int AMMO_MAX = 5,
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [NUM_PLAYERS-1:0] fire_req,
  input  logic [NUM_PLAYERS-1:0] face,
  input  logic [NUM_PLAYERS-1:0] reload,
  ball_slot_scheduler_if.master  slots,
  output logic [NUM_PLAYERS-1:0] grant,
  output logic [CW-1:0]          active_cnt0,
  output logic [CW-1:0]          active_cnt1,
  output logic                   rr_prio
);
  localparam int CDW = $clog2(COOLDOWN + 2);
  logic [NUM_SLOTS-1:0] free, free_lo, rest, free_nx, slot_grant, grant_owner, grant_face;
  logic [NUM_PLAYERS-1:0] owned [NUM_SLOTS];
  logic [CW-1:0] cnt [NUM_PLAYERS];
  logic [CDW-1:0] cd [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] elig, gnt, ammo_ok;
  logic lo_owner;
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    ball_slot_fsm u_slot (
      .frame_clk  (frame_clk),
      .Reset_n    (Reset_n),
      .grant_en   (slot_grant[i]),
      .grant_owner(grant_owner[i]),
      .grant_face (grant_face[i]),
      .slot_active(slots.slot_active[i]),
      .summon     (slots.slot_summon[i]),
      .owner      (slots.slot_owner[i]),
      .face       (slots.slot_face[i]),
      .is_free    (free[i]),
      .is_owned_by(owned[i])
    );
  end
  // free_lo / free_nx isolate the lowest and second-lowest FREE slots as one-hot masks
  always_comb begin
    free_lo = free & -free;
    rest = free & ~free_lo;
    free_nx = rest & -rest;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cnt[p] = '0;
      for (int i = 0; i < NUM_SLOTS; i++) cnt[p] = cnt[p] + CW'(owned[i][p]);
      elig[p] = fire_req[p] && cd[p] == '0 && cnt[p] < CW'(MAX_PER_PLAYER) && |free && ammo_ok[p];
    end
    gnt[0] = elig[0] && (!elig[1] || !rr_prio || |rest);
    gnt[1] = elig[1] && (!elig[0] || rr_prio || |rest);
    lo_owner = &gnt ? rr_prio : gnt[1];
    slot_grant = (|gnt ? free_lo : '0) | (&gnt ? free_nx : '0);
    grant_owner = (free_lo & {NUM_SLOTS{lo_owner}}) | (free_nx & {NUM_SLOTS{!rr_prio}});
    grant_face = (free_lo & {NUM_SLOTS{face[lo_owner]}}) | (free_nx & {NUM_SLOTS{face[!rr_prio]}});
  end
  assign active_cnt0 = cnt[PLAYER0];
  assign active_cnt1 = cnt[PLAYER1];
  // rr_prio only moves when both contend and a single slot is left
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      grant <= '0;
      rr_prio <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) cd[p] <= '0;
    end else begin
      grant <= gnt;
      rr_prio <= rr_prio ^ (&elig && !(|rest));
      for (int p = 0; p < NUM_PLAYERS; p++)
        cd[p] <= gnt[p] ? CDW'(COOLDOWN) : cd[p] - CDW'(cd[p] != '0);
    end
`ifdef AMMO_LIMIT_EN
  localparam int AW = $clog2(AMMO_MAX + 1);
  logic [AW-1:0] ammo [NUM_PLAYERS];
  // reload overrides a same-frame grant decrement
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) ammo[p] <= AW'(AMMO_MAX);
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++)
        ammo[p] <= reload[p] ? AW'(AMMO_MAX) : ammo[p] - AW'(gnt[p]);
    end
  assign ammo_ok = {ammo[1] != '0, ammo[0] != '0};
`else
  logic unused_reload;
  assign unused_reload = ^reload ^ (AMMO_MAX != 0);
  assign ammo_ok = '1;
`endif
endmodule

// File: tb/tb_ball_slot_scheduler.sv
// tb_ball_slot_scheduler: directed scenarios plus randomized traffic against a slot-pool reference model
module tb_ball_slot_scheduler;
  import ball_pkg::*;
  localparam int NS = 3;
  localparam int CD = 10;
  localparam int MAXP = 2;
  localparam int AMAX = 5;
  localparam int CW = $clog2(NS + 1);
  logic frame_clk = 1'b0;
  logic Reset_n = 1'b1;
  logic [1:0] fire_req = '0, face = '0, reload = '0, grant;
  logic [CW-1:0] active_cnt0, active_cnt1;
  logic rr_prio;
  ball_slot_scheduler_if #(.NUM_SLOTS(NS)) sif ();
  ball_slot_scheduler #(
    .NUM_SLOTS(NS), .COOLDOWN(CD), .MAX_PER_PLAYER(MAXP), .AMMO_MAX(AMAX)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_req(fire_req), .face(face),
    .reload(reload), .slots(sif), .grant(grant), .active_cnt0(active_cnt0),
    .active_cnt1(active_cnt1), .rr_prio(rr_prio)
  );
  always #5 frame_clk = ~frame_clk;
  int errors = 0, checks = 0;
  bit m_busy[NS], m_owner[NS], m_face[NS];
  int m_age[NS], life[NS];
  int m_last[2], m_ammo[2];
  bit m_rr, auto_ball;
  logic [1:0] m_grant;
  int edge_n;
  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_face[i] = 0; m_age[i] = 0; life[i] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      m_last[p] = -1000; m_ammo[p] = AMAX;
    end
    m_rr = 0; m_grant = '0; edge_n = 0;
  endtask
  task automatic give(input int p, input int s);
    m_busy[s] = 1; m_owner[s] = p[0]; m_face[s] = face[p]; m_age[s] = 0;
    m_last[p] = edge_n; m_grant[p] = 1'b1; m_ammo[p]--;
  endtask
  task automatic model_eval();
    int fq[$];
    int cnt[2];
    bit el[2];
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < NS; i++) if (!m_busy[i]) fq.push_back(i); else cnt[m_owner[i]]++;
    for (int p = 0; p < 2; p++) begin
      el[p] = fire_req[p] && (edge_n - m_last[p] > CD) && cnt[p] < MAXP && fq.size() > 0;
`ifdef AMMO_LIMIT_EN
      el[p] = el[p] && m_ammo[p] > 0;
`endif
    end
    for (int i = 0; i < NS; i++)
      if (m_busy[i]) begin
        if (m_age[i] >= 1 && !sif.slot_active[i]) m_busy[i] = 0;
        m_age[i]++;
      end
    m_grant = '0;
    if (el[0] && el[1]) begin
      give(int'(m_rr), fq[0]);
      if (fq.size() > 1) give(int'(!m_rr), fq[1]);
      else m_rr = !m_rr;
    end else if (el[0]) give(0, fq[0]);
    else if (el[1]) give(1, fq[0]);
`ifdef AMMO_LIMIT_EN
    for (int p = 0; p < 2; p++) if (reload[p]) m_ammo[p] = AMAX;
`endif
    edge_n++;
  endtask
  function automatic logic [NS-1:0] exp_summon();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_busy[i] && m_age[i] == 0;
    return v;
  endfunction
  function automatic logic [NS-1:0] exp_owner();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_owner[i];
    return v;
  endfunction
  function automatic logic [NS-1:0] exp_face();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_face[i];
    return v;
  endfunction
  function automatic logic [CW-1:0] exp_cnt(input int p);
    int n = 0;
    for (int i = 0; i < NS; i++) if (m_busy[i] && m_owner[i] == p[0]) n++;
    return CW'(n);
  endfunction
  task automatic step();
    bit launching[NS];
    for (int i = 0; i < NS; i++) launching[i] = m_busy[i] && m_age[i] == 0;
    model_eval();
    @(posedge frame_clk);
    #1;
    if (auto_ball)
      for (int i = 0; i < NS; i++) begin
        if (launching[i]) life[i] = $urandom_range(1, 5);
        else if (life[i] > 0) life[i]--;
        sif.slot_active[i] = life[i] > 0;
      end
  endtask
  task automatic do_reset();
    Reset_n = 1'b0; fire_req = '0; reload = '0; face = '0; sif.slot_active = '0; auto_ball = 0;
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    model_reset();
  endtask
  task automatic test_reset();
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, sif.slot_summon, sif.slot_owner, sif.slot_face} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h want 0", {grant, sif.slot_summon, sif.slot_owner, sif.slot_face});
    end
    checks++;
    if ({active_cnt0, active_cnt1, rr_prio} !== '0) begin
      errors++; $display("FAIL reset_counts: got %0h want 0", {active_cnt0, active_cnt1, rr_prio});
    end
    do_reset();
  endtask
  task automatic test_single_shot();
    do_reset();
    face = 2'b01; fire_req = 2'b01;
    step();
    checks++;
    if ({grant, sif.slot_summon} !== {2'b01, 3'b001}) begin
      errors++; $display("FAIL single_grant: got %0h want %0h", {grant, sif.slot_summon}, {2'b01, 3'b001});
    end
    checks++;
    if ({sif.slot_owner[0], sif.slot_face[0]} !== 2'b01) begin
      errors++; $display("FAIL single_latch: got %0b want 01", {sif.slot_owner[0], sif.slot_face[0]});
    end
    fire_req = '0; sif.slot_active[0] = 1'b1;
    step();
    checks++;
    if ({grant, sif.slot_summon, active_cnt0} !== {2'b00, 3'b000, CW'(1)}) begin
      errors++; $display("FAIL single_flight: got %0h want %0h", {grant, sif.slot_summon, active_cnt0}, {2'b00, 3'b000, CW'(1)});
    end
    repeat (20) step();
    checks++;
    if (active_cnt0 !== CW'(1)) begin
      errors++; $display("FAIL single_held: got %0d want 1", active_cnt0);
    end
    sif.slot_active[0] = 1'b0;
    step();
    checks++;
    if (active_cnt0 !== '0) begin
      errors++; $display("FAIL single_expire: got %0d want 0", active_cnt0);
    end
    fire_req = 2'b01;
    step();
    checks++;
    if (sif.slot_summon !== 3'b001) begin
      errors++; $display("FAIL single_reuse: got %0b want 001", sif.slot_summon);
    end
    fire_req = '0;
  endtask
  task automatic test_cooldown();
    int n = 0, first = 0, second = 0;
    do_reset();
    sif.slot_active = '1; fire_req = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (grant[0]) begin
        n++;
        if (n == 1) first = k;
        else if (n == 2) second = k;
      end
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL cooldown_count: got %0d want 2", n);
    end
    checks++;
    if (first != 1 || second != 12) begin
      errors++; $display("FAIL cooldown_frames: got %0d,%0d want 1,12", first, second);
    end
    checks++;
    if (active_cnt0 !== CW'(2)) begin
      errors++; $display("FAIL cooldown_cnt: got %0d want 2", active_cnt0);
    end
    fire_req = '0;
  endtask
  task automatic test_dual_grant();
    do_reset();
    face = 2'b10; fire_req = 2'b11;
    step();
    checks++;
    if ({grant, sif.slot_summon, rr_prio} !== {2'b11, 3'b011, 1'b0}) begin
      errors++; $display("FAIL dual_grant: got %0h want %0h", {grant, sif.slot_summon, rr_prio}, {2'b11, 3'b011, 1'b0});
    end
    checks++;
    if ({sif.slot_owner, sif.slot_face} !== {3'b010, 3'b010}) begin
      errors++; $display("FAIL dual_latch: got %0h want %0h", {sif.slot_owner, sif.slot_face}, {3'b010, 3'b010});
    end
    checks++;
    if ({active_cnt0, active_cnt1} !== {CW'(1), CW'(1)}) begin
      errors++; $display("FAIL dual_cnt: got %0d,%0d want 1,1", active_cnt0, active_cnt1);
    end
    fire_req = '0;
  endtask
  task automatic test_contention();
    do_reset();
    sif.slot_active = '1; fire_req = 2'b11;
    step();
    fire_req = '0;
    repeat (10) step();
    fire_req = 2'b11;
    step();
    checks++;
    if ({grant, sif.slot_summon, rr_prio} !== {2'b01, 3'b100, 1'b1}) begin
      errors++; $display("FAIL contend_p0: got %0h want %0h", {grant, sif.slot_summon, rr_prio}, {2'b01, 3'b100, 1'b1});
    end
    fire_req = '0; sif.slot_active = 3'b110;
    step();
    checks++;
    if (active_cnt0 !== CW'(1)) begin
      errors++; $display("FAIL contend_free: got %0d want 1", active_cnt0);
    end
    repeat (9) step();
    fire_req = 2'b11;
    step();
    checks++;
    if ({grant, sif.slot_summon, rr_prio} !== {2'b10, 3'b001, 1'b0}) begin
      errors++; $display("FAIL contend_p1: got %0h want %0h", {grant, sif.slot_summon, rr_prio}, {2'b10, 3'b001, 1'b0});
    end
    checks++;
    if (sif.slot_owner !== 3'b011) begin
      errors++; $display("FAIL contend_owner: got %0b want 011", sif.slot_owner);
    end
    fire_req = '0;
  endtask
  task automatic test_reset_mid_flight();
    do_reset();
    sif.slot_active = '1; fire_req = 2'b11;
    step();
    fire_req = '0;
    repeat (10) step();
    fire_req = 2'b01;
    step();
    checks++;
    if (sif.slot_summon !== 3'b100) begin
      errors++; $display("FAIL midrst_launch: got %0b want 100", sif.slot_summon);
    end
    fire_req = '0;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, sif.slot_summon, sif.slot_owner, sif.slot_face, active_cnt0, active_cnt1, rr_prio} !== '0) begin
      errors++; $display("FAIL midrst_async: got %0h want 0", {grant, sif.slot_summon, sif.slot_owner, sif.slot_face, active_cnt0, active_cnt1, rr_prio});
    end
    @(posedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    model_reset();
    face = 2'b10; fire_req = 2'b10;
    step();
    checks++;
    if ({grant, sif.slot_summon, sif.slot_owner} !== {2'b10, 3'b001, 3'b001}) begin
      errors++; $display("FAIL midrst_regrant: got %0h want %0h", {grant, sif.slot_summon, sif.slot_owner}, {2'b10, 3'b001, 3'b001});
    end
    fire_req = '0;
  endtask
`ifdef AMMO_LIMIT_EN
  task automatic test_ammo();
    int n = 0;
    do_reset();
    fire_req = 2'b01;
    for (int k = 0; k < 80; k++) begin
      step();
      if (grant[0]) n++;
    end
    checks++;
    if (n != AMAX) begin
      errors++; $display("FAIL ammo_limit: got %0d want %0d", n, AMAX);
    end
    reload = 2'b01;
    step();
    reload = '0; n = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (grant[0]) n++;
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL ammo_reload: got %0d want 1", n);
    end
    fire_req = '0;
  endtask
`endif
  task automatic test_random();
    do_reset();
    auto_ball = 1;
    for (int k = 0; k < 600; k++) begin
      fire_req = 2'($urandom_range(0, 3));
      face = 2'($urandom_range(0, 3));
      reload = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
      step();
      checks++;
      if ({grant, sif.slot_summon} !== {m_grant, exp_summon()}) begin
        errors++; $display("FAIL rand_grant_summon step %0d: got %0h want %0h", k, {grant, sif.slot_summon}, {m_grant, exp_summon()});
      end
      checks++;
      if ({sif.slot_owner, sif.slot_face} !== {exp_owner(), exp_face()}) begin
        errors++; $display("FAIL rand_owner_face step %0d: got %0h want %0h", k, {sif.slot_owner, sif.slot_face}, {exp_owner(), exp_face()});
      end
      checks++;
      if ({active_cnt0, active_cnt1, rr_prio} !== {exp_cnt(0), exp_cnt(1), m_rr}) begin
        errors++; $display("FAIL rand_cnt_rr step %0d: got %0h want %0h", k, {active_cnt0, active_cnt1, rr_prio}, {exp_cnt(0), exp_cnt(1), m_rr});
      end
    end
    auto_ball = 0; fire_req = '0; reload = '0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    model_reset();
    test_reset();
    test_single_shot();
    test_cooldown();
    test_dual_grant();
    test_contention();
    test_reset_mid_flight();
`ifdef AMMO_LIMIT_EN
    test_ammo();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ball_slot_scheduler.md
Name: ball_slot_scheduler

Overview:
- Owns a pool of NUM_SLOTS projectile slots; each slot is one ball-motion instance with summon / summoned handshake.
- Arbitrates fire requests from two players, enforces per-player cooldown and active-ball limits, picks a free slot, issues a one-frame summon, and tracks the slot until its ball expires.
- Sits between the keyboard/player-state logic and the ball instances; the top level muxes player position and face into each slot using slot_owner.

Parameters:
- NUM_SLOTS, 4, number of ball slots managed (2..8).
- COOLDOWN, 10, frames after a grant before the same player may be granted again.
- MAX_PER_PLAYER, 2, maximum slots owned by one player in LAUNCH or FLIGHT.
- AMMO_MAX, 5, ammo capacity per player (AMMO_LIMIT_EN only).

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- fire_req  in  2  level fire request, bit p = player p.
- face  in  2  current facing of each player, sampled at grant.
- slot_active  in  NUM_SLOTS  summoned flag returned by each slot.
- reload  in  2  one-frame refill pulse per player (used only with AMMO_LIMIT_EN).
- slot_summon  out  NUM_SLOTS  summon strobe to each slot.
- slot_owner  out  NUM_SLOTS  owning player of each slot, latched at grant.
- slot_face  out  NUM_SLOTS  face latched at grant.
- grant  out  2  one-frame pulse when player p was given a slot.
- active_cnt0, active_cnt1  out  $clog2(NUM_SLOTS+1)  slots held by each player.
- rr_prio  out  1  player favoured at the next contested grant.

Behaviour:
- Per-slot FSM with states FREE, LAUNCH and FLIGHT.
  - FREE→LAUNCH on grant to that slot.
  - LAUNCH→FLIGHT unconditionally after exactly one frame.
  - FLIGHT→FREE when slot_active==0.
- slot_summon[i] = (state==LAUNCH), decoded from registered state. Exactly one high frame per grant.
- Slot latency: the ball samples summon at the LAUNCH→FLIGHT edge, so slot_active is 1 the next frame.
  - In FLIGHT, slot_active==0 on the first FLIGHT frame means the slot never launched; the slot still returns to FREE.
- Eligibility of player p, all conditions required:
  - fire_req[p]==1
  - cooldown_p==0
  - active_cnt_p < MAX_PER_PLAYER
  - at least one FREE slot
- Slot choice is always lowest-index FREE slot(s).
- Both players eligible, at least 2 FREE slots: both granted. Player rr_prio takes the lowest FREE slot, the other takes the next. rr_prio unchanged.
- Both players eligible, exactly 1 FREE slot: only rr_prio is granted, then rr_prio toggles.
- One player eligible: that player is granted. rr_prio unchanged.
- Grant actions: slot_owner[i] <= p, slot_face[i] <= face[p], grant[p] pulses the same frame the slot enters LAUNCH, cooldown_p <= COOLDOWN.
- cooldown_p decrements by 1 per frame while nonzero and saturates at 0.
  - A held fire_req fires every COOLDOWN+1 frames while resources allow.
- active_cnt_p = count of slots in LAUNCH or FLIGHT with owner p, registered. A grant and an expiry in the same frame leave the count unchanged.
- A slot freed this frame (FLIGHT→FREE) is not grantable until the next frame.
- Reset values:
  - all slots FREE
  - slot_summon, slot_owner, slot_face, grant = 0
  - cooldowns = 0, counts = 0, rr_prio = 0
- Reset mid-flight abandons tracking. The ball instances share Reset_n, so they clear too.

Optional Feature:
- Macro: AMMO_LIMIT_EN.
- Defined:
  - per-player ammo_p counter, width $clog2(AMMO_MAX+1), reset to AMMO_MAX
  - ammo_p>0 is an extra eligibility term
  - decrement on grant; reload[p] sets AMMO_MAX
  - reload and grant in the same frame: reload wins
- Undefined: no ammo state, reload ignored, unlimited shots.

Decomposition:
- Shared package ball_pkg holds:
  - slot_state_t enum (FREE, LAUNCH, FLIGHT)
  - constants PLAYER0=0, PLAYER1=1, NUM_PLAYERS=2
- Sub-module ball_slot_fsm, one instance per slot: state register plus owner/face latch, exposes is_free and is_owned_by.
- Arbitration, cooldown and counters stay in the top module.

Test Plan:
- Single shot: P0 holds fire_req 1 frame, face=1 → grant[0] at frame 1, slot_summon[0] one frame, slot_face[0]=1. Drop slot_active 20 frames later → slot 0 FREE, active_cnt0 0.
- Cooldown: P0 holds fire_req, balls never expire, MAX_PER_PLAYER=2 → grants at frames 1 and 12 only, no third grant.
- Contention: slots 0–2 in FLIGHT, both players request → only P0 granted (rr_prio 0→1). Free one more slot 11 frames later, both request → P1 granted.
- Dual grant: all 4 FREE, both request → P0 on slot 0, P1 on slot 1 same frame, rr_prio stays 0.
- Reset mid-flight: assert Reset_n low during LAUNCH of slot 2 → all outputs 0 immediately, asynchronously. After release, first request gets slot 0.
- AMMO_LIMIT_EN: AMMO_MAX=5, COOLDOWN=0, ball expiry forced → 5 grants to P0 then none. reload[0] pulse → grants resume.
